// File: rtl/i2c_master_nbyte_pkg.sv
// Shared types and constants for the N-byte I2C master: FSM state encoding,
// SCL quarter-phase names, ACK/NACK bus levels and address field widths.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WR_BYTE  = 4'd4,
    S_WR_ACK   = 4'd5,
    S_RD_BYTE  = 4'd6,
    S_RD_ACK   = 4'd7,
    S_STOP     = 4'd8
  } state_e;

  localparam logic [1:0] PH_LOW0  = 2'd0;
  localparam logic [1:0] PH_LOW1  = 2'd1;
  localparam logic [1:0] PH_HIGH0 = 2'd2;
  localparam logic [1:0] PH_HIGH1 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int ADDR_W  = 7;
  localparam int RNW_W   = 1;
  localparam int ABYTE_W = ADDR_W + RNW_W;

endpackage

// File: rtl/i2c_master_nbyte_if.sv
// CPU-side request/status and I2C bus signals of the N-byte master.
// SCL_IN exists only when I2C_CLK_STRETCH_EN is defined.
interface i2c_master_nbyte_if #(
  parameter int NBYTES = 2
);
  logic                       START_STB;
  logic                       RNW;
  logic [i2c_pkg::ADDR_W-1:0] I2C_ADDR;
  logic [8*NBYTES-1:0]        WR_DATA;
  logic                       SDA_IN;
`ifdef I2C_CLK_STRETCH_EN
  logic                       SCL_IN;
`endif
  logic                       SCL;
  logic                       SDA_OUT;
  logic                       SDA_OE;
  logic [8*NBYTES-1:0]        RD_DATA;
  logic                       BUSY;
  logic                       DONE;
  logic                       NACK;

  modport master (
`ifdef I2C_CLK_STRETCH_EN
    input  SCL_IN,
`endif
    input  START_STB, RNW, I2C_ADDR, WR_DATA, SDA_IN,
    output SCL, SDA_OUT, SDA_OE, RD_DATA, BUSY, DONE, NACK
  );

  modport slave (
`ifdef I2C_CLK_STRETCH_EN
    output SCL_IN,
`endif
    output START_STB, RNW, I2C_ADDR, WR_DATA, SDA_IN,
    input  SCL, SDA_OUT, SDA_OE, RD_DATA, BUSY, DONE, NACK
  );
endinterface

// File: rtl/i2c_master_nbyte_scl_gen.sv
// SCL quarter-phase engine: DIV clk per quarter, 4 quarters per SCL period.
// With I2C_CLK_STRETCH_EN the high quarter waits for the bus SCL to read back 1.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       scl_in_i,
`endif
  output logic [1:0] phase_o,
  output logic       upd_o,
  output logic       smp_o,
  output logic       scl_o
);
  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [QW-1:0] q_q, q_d;
  logic [1:0]    ph_q, ph_d;
  logic          hold, wrap;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = (ph_q == PH_HIGH0) && !scl_in_i;
`else
  assign hold = 1'b0;
`endif
  assign wrap = (q_q == QW'(DIV - 1)) && !hold;

  always_comb begin
    q_d  = q_q;
    ph_d = ph_q;
    if (!run_i) begin
      q_d  = '0;
      ph_d = PH_LOW0;
    end else if (!hold) begin
      if (wrap) begin
        q_d  = '0;
        ph_d = ph_q + 2'd1;
      end else begin
        q_d  = q_q + QW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q  <= '0;
      ph_q <= PH_LOW0;
    end else begin
      q_q  <= q_d;
      ph_q <= ph_d;
    end
  end

  // upd marks the edge entering phase 0, smp the edge leaving phase 2
  assign phase_o = ph_q;
  assign upd_o   = run_i && wrap && (ph_q == PH_HIGH1);
  assign smp_o   = run_i && wrap && (ph_q == PH_HIGH0);
  assign scl_o   = ph_q[1];
endmodule

// File: rtl/i2c_master_nbyte.sv
// I2C master: START, address+RNW, NBYTES data bytes with ACK handling, STOP.
// Optional clock stretching via I2C_CLK_STRETCH_EN (adds bus.SCL_IN).
module i2c_master_nbyte
  import i2c_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int DIV    = 4
) (
  input logic                clk,
  input logic                rst,
  i2c_master_nbyte_if.master bus
);
  localparam int DW = 8 * NBYTES;
  localparam int BW = $clog2(NBYTES + 1);

  state_e               state_q, state_d;
  logic [ABYTE_W-1:0]   addr_q, addr_d;
  logic [DW-1:0]        dat_q, dat_d;
  logic [DW-1:0]        rd_q, rd_d;
  logic [2:0]           bit_q, bit_d;
  logic [BW-1:0]        byte_q, byte_d;
  logic                 smp_q, smp_d;
  logic                 rnw_q, rnw_d;
  logic                 nack_q, nack_d;
  logic                 done_q, done_d;

  logic [1:0] phase;
  logic       upd, smp, scl_raw, run, last;

  assign run  = (state_q != S_IDLE);
  assign last = (byte_q == BW'(NBYTES - 1));

  i2c_scl_gen #(.DIV(DIV)) u_scl (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in_i (bus.SCL_IN),
`endif
    .phase_o  (phase),
    .upd_o    (upd),
    .smp_o    (smp),
    .scl_o    (scl_raw)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    smp_d   = smp_q;
    rnw_d   = rnw_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a request in the DONE cycle is dropped, not deferred
        if (bus.START_STB && !done_q) begin
          state_d = S_START;
          addr_d  = {bus.I2C_ADDR, bus.RNW};
          rnw_d   = bus.RNW;
          dat_d   = bus.WR_DATA;
          nack_d  = 1'b0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_START: if (upd) state_d = S_ADDR;
      S_ADDR: if (upd) begin
        addr_d = {addr_q[ABYTE_W-2:0], 1'b0};
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        if (smp) smp_d = bus.SDA_IN;
        if (upd) begin
          if (smp_q == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = rnw_q ? S_RD_BYTE : S_WR_BYTE;
          end
        end
      end
      S_WR_BYTE: if (upd) begin
        dat_d = {dat_q[DW-2:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_WR_ACK;
      end
      S_WR_ACK: begin
        if (smp) smp_d = bus.SDA_IN;
        if (upd) begin
          byte_d = byte_q + BW'(1);
          if (smp_q == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = last ? S_STOP : S_WR_BYTE;
          end
        end
      end
      S_RD_BYTE: begin
        if (smp) dat_d = {dat_q[DW-2:0], bus.SDA_IN};
        if (upd) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_RD_ACK;
        end
      end
      S_RD_ACK: if (upd) begin
        byte_d  = byte_q + BW'(1);
        state_d = last ? S_STOP : S_RD_BYTE;
      end
      S_STOP: if (upd) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (rnw_q && !nack_q) rd_d = dat_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
      rd_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      smp_q   <= 1'b0;
      rnw_q   <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      smp_q   <= smp_d;
      rnw_q   <= rnw_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

  // bus pins decode straight from state/phase so a reset releases them at once
  always_comb begin
    bus.SCL     = 1'b1;
    bus.SDA_OE  = 1'b0;
    bus.SDA_OUT = 1'b1;
    case (state_q)
      S_START: begin
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = (phase <= PH_LOW1);
      end
      S_ADDR: begin
        bus.SCL     = scl_raw;
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = addr_q[ABYTE_W-1];
      end
      S_WR_BYTE: begin
        bus.SCL     = scl_raw;
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = dat_q[DW-1];
      end
      S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: bus.SCL = scl_raw;
      S_RD_ACK: begin
        bus.SCL     = scl_raw;
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = last ? I2C_NACK : I2C_ACK;
      end
      S_STOP: begin
        bus.SCL     = (phase != PH_LOW0);
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = (phase >= PH_HIGH0);
      end
      default: ;
    endcase
  end

  assign bus.RD_DATA = rd_q;
  assign bus.BUSY    = run;
  assign bus.DONE    = done_q;
  assign bus.NACK    = nack_q;
endmodule
